// File: rtl/state_snapshot_arbiter_pkg.sv
// Shared types for the snapshot arbiter: FSM state encoding and snapshot length.
package state_snapshot_arbiter_pkg;
  localparam int unsigned SNAP_LEN_W = 16;

  typedef logic [SNAP_LEN_W-1:0] snap_len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FREEZE,
    ST_START,
    ST_STREAM,
    ST_FINISH
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant starting the search at ptr, plus the pointer after the winner.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [PW-1:0] next_ptr_c,
  output logic          any_c
);
  always_comb begin
    gnt_c      = '0;
    next_ptr_c = ptr;
    any_c      = 1'b0;
    // First pass searches ptr..N-1, second pass wraps around to 0..ptr-1.
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_c && req[i] && (PW'(i) >= ptr)) begin
        gnt_c[i]   = 1'b1;
        next_ptr_c = (i == N - 1) ? '0 : PW'(i + 1);
        any_c      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_c && req[i]) begin
        gnt_c[i]   = 1'b1;
        next_ptr_c = (i == N - 1) ? '0 : PW'(i + 1);
        any_c      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/state_snapshot_arbiter.sv
// Arbitrates snapshot requests, freezes machine state, and forwards the serializer byte stream to the owner.
module state_snapshot_arbiter
  import state_snapshot_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned FREEZE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output snap_len_t          snap_len,
  output logic               freeze,
  output logic               ser_start,
  input  logic               ser_ready,
  input  logic               ser_valid,
  input  logic [7:0]         ser_byte,
  input  logic               ser_byte_valid,
  output logic               ser_byte_ready,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic [NUM_REQ-1:0] out_ready
);
  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned FW = 4;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  snap_len_t          snap_len_q, snap_len_d;
  snap_len_t          bcnt_q, bcnt_d;
  logic               freeze_q, freeze_d;
  logic               ser_start_q, ser_start_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;

  logic [NUM_REQ-1:0] arb_gnt_c;
  logic [PW-1:0]      arb_next_ptr_c;
  logic               arb_any_c;
  logic               is_stream_c, owner_ready_c, hs_c, timeout_c;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr_arbiter (
    .req        (req),
    .ptr        (rr_ptr_q),
    .gnt_c      (arb_gnt_c),
    .next_ptr_c (arb_next_ptr_c),
    .any_c      (arb_any_c)
  );

  // Zero-latency pass-through while streaming; everything is held low otherwise.
  assign is_stream_c    = (state_q == ST_STREAM);
  assign owner_ready_c  = |(out_ready & grant_q);
  assign hs_c           = is_stream_c & ser_byte_valid & owner_ready_c;
  assign ser_byte_ready = is_stream_c & owner_ready_c;
  assign out_valid      = is_stream_c & ser_byte_valid;
  assign out_byte       = is_stream_c ? ser_byte : 8'h00;

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign snap_len  = snap_len_q;
  assign freeze    = freeze_q;
  assign ser_start = ser_start_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = '0;
    snap_len_d  = snap_len_q;
    bcnt_d      = bcnt_q;
    freeze_d    = freeze_q;
    ser_start_d = 1'b0;
    fcnt_d      = fcnt_q;
    tcnt_d      = tcnt_q;
    timeout_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_c) begin
          grant_d  = arb_gnt_c;
          rr_ptr_d = arb_next_ptr_c;
          freeze_d = 1'b1;
          fcnt_d   = '0;
          state_d  = ST_FREEZE;
        end
      end
      ST_FREEZE: begin
        if (fcnt_q == FW'(FREEZE_CYCLES - 1)) begin
          state_d = ST_START;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      ST_START: begin
        if (ser_ready) begin
          ser_start_d = 1'b1;
          bcnt_d      = '0;
          tcnt_d      = '0;
          state_d     = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (hs_c) begin
          if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
          tcnt_d = '0;
        end else begin
          tcnt_d    = tcnt_q + 1'b1;
          timeout_c = (tcnt_q == TW'(TIMEOUT - 1));
        end
        // Serializer completion wins over a coincident timeout.
        if (ser_valid || timeout_c) begin
          snap_len_d = bcnt_d;
          freeze_d   = 1'b0;
          grant_d    = '0;
          state_d    = ST_FINISH;
          if (ser_valid) done_d = grant_q;
          else           err_d  = grant_q;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      snap_len_q  <= '0;
      bcnt_q      <= '0;
      freeze_q    <= 1'b0;
      ser_start_q <= 1'b0;
      fcnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      snap_len_q  <= snap_len_d;
      bcnt_q      <= bcnt_d;
      freeze_q    <= freeze_d;
      ser_start_q <= ser_start_d;
      fcnt_q      <= fcnt_d;
      tcnt_q      <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_state_snapshot_arbiter.sv
// Directed and randomized snapshots against a cycle-level reference of the arbitration/stream rules.
module tb_state_snapshot_arbiter;
  localparam int NR  = 3;
  localparam int FRZ = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] out_ready = '0;
  logic          ser_ready = 1'b0;
  logic          ser_valid = 1'b0;
  logic [7:0]    ser_byte = 8'h00;
  logic          ser_byte_valid = 1'b0;
  logic [NR-1:0] grant, done, err;
  logic [15:0]   snap_len;
  logic          freeze, ser_start, ser_byte_ready, out_valid;
  logic [7:0]    out_byte;

  int vectors     = 0;
  int miscompares = 0;
  int exp_ptr     = 0;

  state_snapshot_arbiter #(.NUM_REQ(NR), .FREEZE_CYCLES(FRZ), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .grant          (grant),
    .done           (done),
    .err            (err),
    .snap_len       (snap_len),
    .freeze         (freeze),
    .ser_start      (ser_start),
    .ser_ready      (ser_ready),
    .ser_valid      (ser_valid),
    .ser_byte       (ser_byte),
    .ser_byte_valid (ser_byte_valid),
    .ser_byte_ready (ser_byte_ready),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"},    32'(grant), 0);
    check({tag, "_done"},     32'(done), 0);
    check({tag, "_err"},      32'(err), 0);
    check({tag, "_snap_len"}, 32'(snap_len), 0);
    check({tag, "_freeze"},   32'(freeze), 0);
    check({tag, "_start"},    32'(ser_start), 0);
    check({tag, "_bready"},   32'(ser_byte_ready), 0);
    check({tag, "_ovalid"},   32'(out_valid), 0);
    check({tag, "_obyte"},    32'(out_byte), 0);
  endtask

  // One snapshot: the bench acts as serializer and sink, and predicts owner, bytes, length and outcome.
  task automatic run_snap(input string tag, input logic [NR-1:0] mask, input int len,
                          input int rdy_pct, input int vld_pct, input int stall_at,
                          input int abort_at, input int sdly);
    logic [7:0]    data[$];
    logic [NR-1:0] wm;
    int            w, cyc, idx, idle, start_cyc, starts, exp_end;
    bit            active, fin, aborted, hs, own_rdy;
    data = {};
    for (int i = 0; i < len; i++) data.push_back(8'($urandom));
    w = -1;
    for (int k = 0; k < NR; k++)
      if (w < 0 && ((int'(mask) >> ((exp_ptr + k) % NR)) & 1) == 1) w = (exp_ptr + k) % NR;
    exp_ptr = (w + 1) % NR;
    wm = NR'(1 << w);
    cyc = 0; idx = 0; idle = 0; start_cyc = -1; starts = 0; exp_end = 0;
    active = 1'b0; fin = 1'b0; aborted = 1'b0;
    req = mask;
    ser_ready = 1'b0;
    while (!fin && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      ser_valid = 1'b0;
      ser_byte_valid = 1'b0;
      if (ser_start === 1'b1) begin
        starts++;
        if (start_cyc < 0) start_cyc = cyc;
        active = 1'b1;
      end
      if (exp_end != 0) begin
        check({tag, "_done"}, 32'(done), (exp_end == 1) ? 32'(wm) : 32'd0);
        check({tag, "_err"}, 32'(err), (exp_end == 2) ? 32'(wm) : 32'd0);
        check({tag, "_snap_len"}, 32'(snap_len), 32'(idx));
        check({tag, "_grant_release"}, 32'(grant), 0);
        check({tag, "_freeze_release"}, 32'(freeze), 0);
        check({tag, "_start_cycle"}, 32'(start_cyc), 32'(FRZ + 2 + sdly));
        check({tag, "_start_pulses"}, 32'(starts), 1);
        fin = 1'b1;
      end else begin
        check({tag, "_grant"}, 32'(grant), 32'(wm));
        check({tag, "_freeze"}, 32'(freeze), 1);
        check({tag, "_no_pulse"}, 32'(done | err), 0);
        if (abort_at >= 0 && active && idx >= abort_at) begin
          rst_n = 1'b0;
          #1;
          check_quiet({tag, "_async"});
          repeat (3) begin
            @(posedge clk); #1;
            check({tag, "_reset_no_pulse"}, 32'(done | err | grant), 0);
          end
          req = '0;
          rst_n = 1'b1;
          exp_ptr = 0;
          aborted = 1'b1;
          fin = 1'b1;
        end else begin
          ser_ready = (cyc >= FRZ + 1 + sdly);
          own_rdy = (stall_at >= 0 && idx >= stall_at) ? 1'b0 : ($urandom_range(99) < rdy_pct);
          out_ready = (NR'($urandom) & ~wm) | (own_rdy ? wm : '0);
          if (active) begin
            if (idx < len) begin
              ser_byte_valid = ($urandom_range(99) < vld_pct);
              ser_byte = data[idx];
            end else begin
              ser_valid = 1'b1;
            end
          end else begin
            ser_byte_valid = 1'($urandom);
            ser_byte = 8'($urandom);
          end
          #1;
          if (active) begin
            check({tag, "_ovalid"}, 32'(out_valid), 32'(ser_byte_valid));
            check({tag, "_bready"}, 32'(ser_byte_ready), 32'(own_rdy));
            if (ser_byte_valid) check({tag, "_obyte"}, 32'(out_byte), 32'(data[idx]));
            hs = ser_byte_valid && own_rdy;
            if (hs) begin idx++; idle = 0; end
            else idle++;
            if (ser_valid) exp_end = 1;
            else if (idle >= TMO) exp_end = 2;
          end else begin
            check({tag, "_idle_ovalid"}, 32'(out_valid), 0);
            check({tag, "_idle_bready"}, 32'(ser_byte_ready), 0);
          end
        end
      end
    end
    check({tag, "_completed"}, 32'(fin), 1);
    ser_valid = 1'b0;
    ser_byte_valid = 1'b0;
    if (!aborted) begin
      @(posedge clk); #1;
      check({tag, "_no_regrant"}, 32'(grant), 0);
      check({tag, "_pulse_width"}, 32'(done | err), 0);
    end
  endtask

  initial begin
    int len, rdy, vld, stall, sdly;
    logic [NR-1:0] mask;
    rst_n = 1'b0;
    req = 3'b111;
    ser_ready = 1'b1;
    ser_byte = 8'hA5;
    ser_byte_valid = 1'b1;
    out_ready = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    req = '0;
    ser_byte_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_grant", 32'(grant), 0);

    run_snap("single53", 3'b001, 53, 100, 100, -1, -1, 0);
    req = '0;
    run_snap("abort", 3'b010, 53, 100, 100, -1, 20, 0);
    req = '0;
    run_snap("rr0", 3'b111, 10, 100, 100, -1, -1, 0);
    run_snap("rr1", 3'b111, 12, 100, 100, -1, -1, 1);
    run_snap("rr2", 3'b111, 14, 100, 100, -1, -1, 0);
    req = '0;
    run_snap("half_ready", 3'b001, 53, 50, 100, -1, -1, 0);
    req = '0;
    run_snap("timeout", 3'b010, 53, 100, 100, 20, -1, 0);
    req = '0;
    for (int n = 0; n < 10; n++) begin
      mask  = NR'($urandom_range(1, 7));
      len   = $urandom_range(0, 40);
      rdy   = $urandom_range(40, 100);
      vld   = $urandom_range(50, 100);
      stall = ($urandom_range(3) == 0) ? $urandom_range(0, len) : -1;
      sdly  = $urandom_range(0, 3);
      run_snap("rand", mask, len, rdy, vld, stall, -1, sdly);
      if ($urandom_range(1) == 0) req = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
